// File: rtl/uart_rx_deframer_if.sv
// Byte-stream interface of the UART receive deframer.
// master: the deframer (samples rxIn, drives the byte buffer and status).
// slave : the environment/consumer (drives the line and rxReady).
`timescale 1ns/1ps

interface uart_rx_deframer_if;
    logic       rxIn;
    logic [7:0] rxData;
    logic       rxValid;
    logic       rxReady;
    logic       frameErr;
    logic       overrun;
    logic       busy;

    modport master (
        input  rxIn,
        input  rxReady,
        output rxData,
        output rxValid,
        output frameErr,
        output overrun,
        output busy
    );

    modport slave (
        output rxIn,
        output rxReady,
        input  rxData,
        input  rxValid,
        input  frameErr,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: 8N1, LSB first, mid-bit sampling timed from the
// start-bit edge, single-entry valid/ready output buffer.
// Optional build macro UART_RX_PARITY_EN adds one even-parity bit between
// the last data bit and the stop bit.
`timescale 1ns/1ps

module uart_rx_deframer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_rx_deframer_if.master  rx
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_STOP      = 3'd3;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd5;
`endif

    // Start check lands half a bit after the edge; every later sample is one
    // full bit period after the previous one, so all samples sit mid-bit.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
`ifdef UART_RX_PARITY_EN
    logic             par_err;
`endif

    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             ovr_q;

    logic             bit_end;
    logic             stop_done;
    logic             good_frame;
    logic             bad_frame;

    // Stop-sample outcome, shared by the FSM and the output buffer.
    always_comb begin
        bit_end    = (bit_cnt == BIT_LAST);
        stop_done  = (state == ST_STOP) && bit_end;
`ifdef UART_RX_PARITY_EN
        good_frame = stop_done && rx.rxIn && !par_err;
`else
        good_frame = stop_done && rx.rxIn;
`endif
        bad_frame  = stop_done && !good_frame;
    end

    // Frame FSM: start qualification, bit timing and data shifting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the shift register is reset along with the counters so a
            // frame aborted by reset can never leak old bits into a later byte.
            state   <= ST_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch below
            // reads the pre-edge values of state and counters.
            case (state)
                ST_IDLE: begin
                    if (!rx.rxIn) begin
                        state   <= ST_START;
                        bit_cnt <= '0;
                    end
                end

                ST_START: begin
                    if (bit_cnt == HALF_LAST) begin
                        if (!rx.rxIn) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                            bit_idx <= '0;
                        end else begin
                            // Glitch shorter than half a bit: silently ignore.
                            state   <= ST_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (bit_end) begin
                        shift[bit_idx] <= rx.rxIn;
                        bit_cnt        <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end) begin
                        // Even parity: data bits plus parity bit XOR to zero.
                        par_err <= rx.rxIn ^ (^shift);
                        bit_cnt <= '0;
                        state   <= ST_STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
`endif

                ST_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= rx.rxIn ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    // A held-low line (break) must not look like a new start bit.
                    if (rx.rxIn) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Single-entry output buffer plus one-cycle error/overrun pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            ferr_q <= bad_frame;
            ovr_q  <= 1'b0;
            if (good_frame) begin
                // A byte arriving in the same cycle as an accept takes the slot.
                if (!valid_q || rx.rxReady) begin
                    data_q  <= shift;
                    valid_q <= 1'b1;
                end else begin
                    ovr_q   <= 1'b1;
                end
            end else if (valid_q && rx.rxReady) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rx.rxData   = data_q;
    assign rx.rxValid  = valid_q;
    assign rx.frameErr = ferr_q;
    assign rx.overrun  = ovr_q;
    assign rx.busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed testbench for uart_rx_deframer (CLKS_PER_BIT = 8).
// A table of frames is replayed with rxReady high, followed by hand-written
// sequences for false start, break, overrun, mid-frame reset and parity.
`timescale 1ns/1ps

module tb_uart_rx_deframer;

    localparam int N = 8;
`ifdef UART_RX_PARITY_EN
    localparam int LAT = 85;   // edge drive -> rxValid visible: 1 + 4 + 10*8
`else
    localparam int LAT = 77;   // edge drive -> rxValid visible: 1 + 4 + 9*8
`endif

    typedef struct {
        logic [7:0] data;
        logic       stop_b;
        logic       exp_valid;
        logic       exp_ferr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_rx_deframer_if rx_if ();

    uart_rx_deframer #(.CLKS_PER_BIT(N), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .rx  (rx_if)
    );

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;
    int start_cyc = 0;
`ifdef UART_RX_PARITY_EN
    logic par_flip;
`endif

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: accepted bytes, error pulses, buffer stability.
    logic [7:0] acc_q[$];
    logic       valid_q = 1'b0;
    logic       ready_q = 1'b0;
    logic [7:0] data_q  = 8'h00;
    int last_rise = -1;
    int last_ovr  = -1;
    int ferr_cnt  = 0;
    int ovr_cnt   = 0;
    int both_cnt  = 0;
    int data_changed = 0;

    always @(negedge clk) begin
        valid_q <= rx_if.rxValid;
        ready_q <= rx_if.rxReady;
        data_q  <= rx_if.rxData;
        if (rx_if.rxValid && !valid_q) last_rise <= cyc;
        if (rx_if.rxValid && rx_if.rxReady) acc_q.push_back(rx_if.rxData);
        if (rx_if.frameErr) ferr_cnt <= ferr_cnt + 1;
        if (rx_if.overrun) begin
            ovr_cnt  <= ovr_cnt + 1;
            last_ovr <= cyc;
        end
        if (rx_if.frameErr && rx_if.overrun) both_cnt <= both_cnt + 1;
        if (rx_if.rxValid && valid_q && !ready_q && rx_if.rxData !== data_q)
            data_changed <= data_changed + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_bit(input logic v);
        rx_if.rxIn = v;
        repeat (N) tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit((^d) ^ par_flip);
`endif
        drive_bit(stop_b);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    vec_t vecs [7];
    int n0, f0, o0, s2;

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h01, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{8'hC3, 1'b1, 1'b1, 1'b0};

        rx_if.rxIn    = 1'b1;
        rx_if.rxReady = 1'b1;
        rst           = 1'b1;
`ifdef UART_RX_PARITY_EN
        par_flip      = 1'b0;
`endif
        repeat (3) tick();
        check("reset rxData",   rx_if.rxData,   0);
        check("reset rxValid",  rx_if.rxValid,  0);
        check("reset frameErr", rx_if.frameErr, 0);
        check("reset overrun",  rx_if.overrun,  0);
        check("reset busy",     rx_if.busy,     0);
        rst = 1'b0;
        repeat (4) tick();
        check("idle after reset busy", rx_if.busy, 0);

        // Table-driven frames, consumer always ready.
        for (int i = 0; i < 7; i++) begin
            n0 = acc_q.size();
            f0 = ferr_cnt;
            o0 = ovr_cnt;
            send_frame(vecs[i].data, vecs[i].stop_b);
            rx_if.rxIn = 1'b1;
            repeat (2 * N) tick();
            check($sformatf("vec%0d accepts", i), acc_q.size() - n0, vecs[i].exp_valid);
            if (vecs[i].exp_valid && acc_q.size() > n0) begin
                check($sformatf("vec%0d data", i), acc_q[$], vecs[i].data);
                check($sformatf("vec%0d latency", i), last_rise - start_cyc, LAT);
            end
            check($sformatf("vec%0d frameErr", i), ferr_cnt - f0, vecs[i].exp_ferr);
            check($sformatf("vec%0d overrun", i), ovr_cnt - o0, 0);
            check($sformatf("vec%0d rxValid idle", i), rx_if.rxValid, 0);
            check($sformatf("vec%0d busy idle", i), rx_if.busy, 0);
        end

        // False start: line low for two cycles only.
        f0 = ferr_cnt;
        n0 = acc_q.size();
        rx_if.rxIn = 1'b0;
        tick();
        tick();
        rx_if.rxIn = 1'b1;
        check("false start busy during check", rx_if.busy, 1);
        repeat (4) tick();
        check("false start busy", rx_if.busy, 0);
        check("false start rxValid", rx_if.rxValid, 0);
        check("false start frameErr", ferr_cnt - f0, 0);
        check("false start accepts", acc_q.size() - n0, 0);
        repeat (N) tick();

        // Break: bad stop bit, line held low, then a normal byte.
        f0 = ferr_cnt;
        n0 = acc_q.size();
        send_frame(8'h3C, 1'b0);
        repeat (40) tick();
        check("break frameErr pulses", ferr_cnt - f0, 1);
        check("break rxValid", rx_if.rxValid, 0);
        check("break wait_high busy", rx_if.busy, 1);
        rx_if.rxIn = 1'b1;
        repeat (2) tick();
        check("break released busy", rx_if.busy, 0);
        send_frame(8'h55, 1'b1);
        repeat (2 * N) tick();
        check("after break accepts", acc_q.size() - n0, 1);
        if (acc_q.size() > n0) check("after break data", acc_q[$], 8'h55);
        check("after break frameErr", ferr_cnt - f0, 1);

        // Overrun: two back-to-back bytes with the consumer stalled.
        rx_if.rxReady = 1'b0;
        n0 = acc_q.size();
        o0 = ovr_cnt;
        f0 = ferr_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        s2 = start_cyc;
        rx_if.rxIn = 1'b1;
        repeat (N) tick();
        check("overrun rxValid held", rx_if.rxValid, 1);
        check("overrun rxData kept", rx_if.rxData, 8'h11);
        check("overrun pulses", ovr_cnt - o0, 1);
        check("overrun timing", last_ovr - s2, LAT);
        check("overrun no frameErr", ferr_cnt - f0, 0);
        rx_if.rxReady = 1'b1;
        tick();
        check("overrun accept drops valid", rx_if.rxValid, 0);
        check("overrun accepts", acc_q.size() - n0, 1);
        if (acc_q.size() > n0) check("overrun accepted data", acc_q[$], 8'h11);
        repeat (2 * N) tick();
        check("overrun second byte gone", rx_if.rxValid, 0);

        // Reset mid-frame with a byte still pending in the buffer.
        rx_if.rxReady = 1'b0;
        send_frame(8'h99, 1'b1);
        rx_if.rxIn = 1'b1;
        repeat (N) tick();
        check("pending byte valid", rx_if.rxValid, 1);
        check("pending byte data", rx_if.rxData, 8'h99);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx_if.rxIn = 1'b1;
        repeat (N / 2) tick();
        check("mid-frame busy", rx_if.busy, 1);
        rst = 1'b1;
        tick();
        check("mid reset rxValid", rx_if.rxValid, 0);
        check("mid reset rxData", rx_if.rxData, 0);
        check("mid reset busy", rx_if.busy, 0);
        check("mid reset frameErr", rx_if.frameErr, 0);
        check("mid reset overrun", rx_if.overrun, 0);
        repeat (2) tick();
        rst = 1'b0;
        rx_if.rxReady = 1'b1;
        repeat (N) tick();
        check("post reset idle", rx_if.busy, 0);
        n0 = acc_q.size();
        send_frame(8'h0F, 1'b1);
        repeat (2 * N) tick();
        check("post reset accepts", acc_q.size() - n0, 1);
        if (acc_q.size() > n0) check("post reset data", acc_q[$], 8'h0F);
        check("post reset latency", last_rise - start_cyc, LAT);

`ifdef UART_RX_PARITY_EN
        // Parity: correct even parity, then flipped parity.
        n0 = acc_q.size();
        f0 = ferr_cnt;
        par_flip = 1'b0;
        send_frame(8'h07, 1'b1);
        repeat (2 * N) tick();
        check("parity good accepts", acc_q.size() - n0, 1);
        if (acc_q.size() > n0) check("parity good data", acc_q[$], 8'h07);
        check("parity good frameErr", ferr_cnt - f0, 0);
        n0 = acc_q.size();
        par_flip = 1'b1;
        send_frame(8'h07, 1'b1);
        rx_if.rxIn = 1'b1;
        repeat (2 * N) tick();
        par_flip = 1'b0;
        check("parity bad accepts", acc_q.size() - n0, 0);
        check("parity bad frameErr", ferr_cnt - f0, 1);
        check("parity bad rxValid", rx_if.rxValid, 0);
`endif

        check("frameErr with overrun", both_cnt, 0);
        check("rxData stable while held", data_changed, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
